// File: rtl/mire_pkg.sv
// Shared constants, colour table and FSM state type for the mire pattern master.
package mire_pkg;

  localparam logic [31:0] WHITE   = 32'h00FFFFFF;
  localparam logic [31:0] BLACK   = 32'h00000000;
  localparam logic [31:0] YELLOW  = 32'h00FFFF00;
  localparam logic [31:0] CYAN    = 32'h0000FFFF;
  localparam logic [31:0] GREEN   = 32'h0000FF00;
  localparam logic [31:0] MAGENTA = 32'h00FF00FF;
  localparam logic [31:0] RED     = 32'h00FF0000;
  localparam logic [31:0] BLUE    = 32'h000000FF;

  localparam int unsigned GRID_PERIOD = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } mire_state_t;

  function automatic logic [31:0] bar_color(input logic [2:0] idx);
    logic [31:0] c;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = YELLOW;
      3'd2:    c = CYAN;
      3'd3:    c = GREEN;
      3'd4:    c = MAGENTA;
      3'd5:    c = RED;
      3'd6:    c = BLUE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone bus bundle shared by the mire writer, the VGA reader and the interconnect.
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    input  clk, rst, ack, dat_sm, err, rty,
    output cyc, stb, we, adr, sel, dat_ms, cti, bte
  );

  modport slave (
    input  clk, rst, cyc, stb, we, adr, sel, dat_ms, cti, bte,
    output ack, dat_sm, err, rty
  );
endinterface

// File: rtl/mire_pos_counter.sv
// Raster position (x, y) and incrementally maintained byte address of the current pixel.
module mire_pos_counter
  #(
    parameter int unsigned HDISP = 800,
    parameter int unsigned VDISP = 480,
    localparam int unsigned XW   = $clog2(HDISP),
    localparam int unsigned YW   = $clog2(VDISP)
  )
  (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [31:0]   adr,
    output logic          frame_end
  );

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [31:0]   adr_q, adr_d;
  logic          line_end;

  assign line_end  = (x_q == XW'(HDISP - 1));
  assign frame_end = line_end && (y_q == YW'(VDISP - 1));

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    adr_d = adr_q;
    if (adv) begin
      if (frame_end) begin
        x_d   = '0;
        y_d   = '0;
        adr_d = '0;
      end else if (line_end) begin
        x_d   = '0;
        y_d   = y_q + YW'(1);
        adr_d = adr_q + 32'd4;
      end else begin
        x_d   = x_q + XW'(1);
        adr_d = adr_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      adr_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      adr_q <= adr_d;
    end
  end

  assign x   = x_q;
  assign y   = y_q;
  assign adr = adr_q;

endmodule

// File: rtl/wshb_mire.sv
// Wishbone master streaming a test pattern into the framebuffer, releasing cyc every BURST_MAX acks.
// Define MIRE_COLORBAR_EN for 8 vertical colour bars instead of the 16-pixel grid.
module wshb_mire
  import mire_pkg::*;
  #(
    parameter int unsigned HDISP     = 800,
    parameter int unsigned VDISP     = 480,
    parameter int unsigned BURST_MAX = 64
  )
  (
    input logic     clk,
    input logic     rst,
    wshb_if.master  wshb_ifm
  );

  localparam int unsigned XW = $clog2(HDISP);
  localparam int unsigned YW = $clog2(VDISP);
  localparam int unsigned GB = $clog2(GRID_PERIOD);

  mire_state_t   state_q, state_d;
  logic [8:0]    burst_q, burst_d;
  logic          adv;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [31:0]   adr;
  logic          frame_end;
  logic [31:0]   pixel;

  assign adv = (state_q == WRITE) && wshb_ifm.ack;

  mire_pos_counter #(
    .HDISP (HDISP),
    .VDISP (VDISP)
  ) u_pos (
    .clk       (clk),
    .rst       (rst),
    .adv       (adv),
    .x         (x),
    .y         (y),
    .adr       (adr),
    .frame_end (frame_end)
  );

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: state_d = WRITE;
      WRITE: begin
        if (wshb_ifm.ack) begin
          if (burst_q == 9'(BURST_MAX - 1)) begin
            burst_d = '0;
            state_d = IDLE;
          end else begin
            burst_d = burst_q + 9'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

`ifdef MIRE_COLORBAR_EN
  localparam int unsigned BAR_W = HDISP / 8;
  localparam int unsigned BW    = $clog2(BAR_W + 1);

  logic [BW-1:0] bar_sub_q, bar_sub_d;
  logic [2:0]    bar_idx_q, bar_idx_d;

  // Bar index tracks x with its own sub-counter so no divide by HDISP/8 is needed.
  always_comb begin
    bar_sub_d = bar_sub_q;
    bar_idx_d = bar_idx_q;
    if (adv) begin
      if (x == XW'(HDISP - 1)) begin
        bar_sub_d = '0;
        bar_idx_d = '0;
      end else if (bar_sub_q == BW'(BAR_W - 1)) begin
        bar_sub_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_sub_d = bar_sub_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_sub_q <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_sub_q <= bar_sub_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  assign pixel = bar_color(bar_idx_q);
`else
  logic [GB-1:0] x_lo;
  logic [GB-1:0] y_lo;

  assign x_lo  = GB'(x);
  assign y_lo  = GB'(y);
  assign pixel = ((x_lo == '0) || (y_lo == '0)) ? WHITE : BLACK;
`endif

  assign wshb_ifm.cyc    = (state_q == WRITE);
  assign wshb_ifm.stb    = (state_q == WRITE);
  assign wshb_ifm.we     = 1'b1;
  assign wshb_ifm.sel    = 4'hF;
  assign wshb_ifm.cti    = '0;
  assign wshb_ifm.bte    = '0;
  assign wshb_ifm.adr    = adr;
  assign wshb_ifm.dat_ms = pixel;

  logic unused_sink;
  assign unused_sink = ^{wshb_ifm.dat_sm, wshb_ifm.err, wshb_ifm.rty,
                         wshb_ifm.clk, wshb_ifm.rst, frame_end, x, y};

endmodule

// File: tb/tb_wshb_mire.sv
// Directed bench for wshb_mire: reset, stall, burst gap, random-ack pattern, frame wrap, async reset.
module tb_wshb_mire;

  localparam int unsigned HA = 800;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wshb_if ifa (.clk(clk), .rst(rst));
  wshb_if ifb (.clk(clk), .rst(rst));

  assign ifa.dat_sm = '0;
  assign ifa.err    = 1'b0;
  assign ifa.rty    = 1'b0;
  assign ifb.dat_sm = '0;
  assign ifb.err    = 1'b0;
  assign ifb.rty    = 1'b0;

  wshb_mire #(.HDISP(800), .VDISP(480), .BURST_MAX(64)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .wshb_ifm (ifa.master)
  );

  wshb_mire #(.HDISP(32), .VDISP(4), .BURST_MAX(128)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .wshb_ifm (ifb.master)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_pix(input int unsigned x, input int unsigned y);
`ifdef MIRE_COLORBAR_EN
    case (x / (HA / 8))
      0:       return 32'h00FFFFFF;
      1:       return 32'h00FFFF00;
      2:       return 32'h0000FFFF;
      3:       return 32'h0000FF00;
      4:       return 32'h00FF00FF;
      5:       return 32'h00FF0000;
      6:       return 32'h000000FF;
      default: return 32'h00000000;
    endcase
`else
    return ((x % 16 == 0) || (y % 16 == 0)) ? 32'h00FFFFFF : 32'h00000000;
`endif
  endfunction

  initial begin
    int unsigned mx;
    int unsigned my;
    int unsigned n;
    bit          done;
    bit          a;

    ifa.ack = 1'b0;
    ifb.ack = 1'b0;
    rst     = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cyc",    ifa.cyc,    0);
    check_eq("rst_stb",    ifa.stb,    0);
    check_eq("rst_we",     ifa.we,     1);
    check_eq("rst_sel",    ifa.sel,    4'hF);
    check_eq("rst_cti",    ifa.cti,    0);
    check_eq("rst_bte",    ifa.bte,    0);
    check_eq("rst_adr",    ifa.adr,    0);
    check_eq("rst_dat",    ifa.dat_ms, 32'h00FFFFFF);
    check_eq("rst_cyc_b",  ifb.cyc,    0);

    // rst released synchronously with this edge; cyc must rise on the next one
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("idle_cycle", ifa.cyc, 0);
    @(negedge clk);
    check_eq("cyc_rise",   ifa.cyc, 1);
    check_eq("stb_rise",   ifa.stb, 1);

    for (int i = 0; i < 100; i++) begin
      check_eq("stall_cyc", ifa.cyc,    1);
      check_eq("stall_adr", ifa.adr,    0);
      check_eq("stall_dat", ifa.dat_ms, 32'h00FFFFFF);
      @(negedge clk);
    end

    ifa.ack = 1'b1;
    for (int i = 0; i < 64; i++) begin
      check_eq("burst_cyc", ifa.cyc,    1);
      check_eq("burst_adr", ifa.adr,    32'(4 * i));
      check_eq("burst_dat", ifa.dat_ms, ref_pix(i, 0));
      @(negedge clk);
    end
    check_eq("burst_gap", ifa.cyc, 0);
    @(negedge clk);
    check_eq("burst_next_cyc", ifa.cyc, 1);
    check_eq("burst_next_adr", ifa.adr, 256);

    mx   = 64;
    my   = 0;
    n    = 0;
    done = 1'b0;
    while (!done && n < 80000) begin
      a       = 1'($urandom_range(0, 1));
      ifa.ack = a;
      if (ifa.cyc && a) begin
        check_eq("rand_adr", ifa.adr,    32'(4 * (my * HA + mx)));
        check_eq("rand_dat", ifa.dat_ms, ref_pix(mx, my));
`ifdef MIRE_COLORBAR_EN
        if (my == 1 && mx == 0)   check_eq("bar_x0",   ifa.dat_ms, 32'h00FFFFFF);
        if (my == 1 && mx == 100) check_eq("bar_x100", ifa.dat_ms, 32'h00FFFF00);
        if (my == 1 && mx == 799) check_eq("bar_x799", ifa.dat_ms, 32'h00000000);
`else
        if (mx == 5  && my == 5)  check_eq("pix_5_5",  ifa.dat_ms, 32'h00000000);
        if (mx == 16 && my == 3)  check_eq("pix_16_3", ifa.dat_ms, 32'h00FFFFFF);
        if (mx == 3  && my == 16) check_eq("pix_3_16", ifa.dat_ms, 32'h00FFFFFF);
`endif
        if (mx == 3 && my == 16) done = 1'b1;
        if (mx == HA - 1) begin
          mx = 0;
          my = my + 1;
        end else begin
          mx = mx + 1;
        end
      end
      @(negedge clk);
      n++;
    end
    check_eq("rand_done", done, 1);
    ifa.ack = 1'b0;

    ifb.ack = 1'b1;
    for (int i = 0; i < 128; i++) begin
      check_eq("wrap_cyc", ifb.cyc, 1);
      check_eq("wrap_adr", ifb.adr, 32'(4 * i));
      @(negedge clk);
    end
    check_eq("wrap_gap", ifb.cyc, 0);
    @(negedge clk);
    check_eq("wrap_cyc_back", ifb.cyc,    1);
    check_eq("wrap_adr0",     ifb.adr,    0);
    check_eq("wrap_dat0",     ifb.dat_ms, 32'h00FFFFFF);

    repeat (10) @(negedge clk);
    check_eq("pre_rst_adr", ifb.adr, 40);
    check_eq("pre_rst_cyc", ifb.cyc, 1);
    ifb.ack = 1'b0;

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_cyc", ifb.cyc,    0);
    check_eq("async_stb", ifb.stb,    0);
    check_eq("async_adr", ifb.adr,    0);
    check_eq("async_dat", ifb.dat_ms, 32'h00FFFFFF);
    check_eq("async_cyc_a", ifa.cyc,  0);

    ifb.ack = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rerst_idle", ifb.cyc, 0);
    @(negedge clk);
    check_eq("rerst_cyc",  ifb.cyc, 1);
    check_eq("rerst_adr0", ifb.adr, 0);
    @(negedge clk);
    check_eq("rerst_adr1", ifb.adr, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
